jpeg_dht_lookup_arb: RTL and testbench

//  Shares one Huffman (DHT) lookup engine between NUM_REQ MCU decode lanes.

---
 rtl/jpeg_dht_lookup_arb_if.sv | 35 +++
 rtl/jpeg_dht_lookup_arb.sv | 132 +++++++++++++
 tb/tb_jpeg_dht_lookup_arb.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_dht_lookup_arb_if.sv
// rtl/jpeg_dht_lookup_arb_if.sv - lane request/response, config and engine signals of the DHT lookup arbiter
interface jpeg_dht_lookup_arb_if #(
  parameter int NUM_REQ = 2
);
  logic                   flush_i;
  logic                   cfg_busy_i;
  logic                   cfg_idle_o;
  logic [NUM_REQ-1:0]     req_valid_i;
  logic [2*NUM_REQ-1:0]   req_table_i;
  logic [16*NUM_REQ-1:0]  req_input_i;
  logic [NUM_REQ-1:0]     rsp_valid_o;
  logic [4:0]             rsp_width_o;
  logic [7:0]             rsp_value_o;
  logic [NUM_REQ-1:0]     req_err_o;
  logic                   lu_req_o;
  logic [1:0]             lu_table_o;
  logic [15:0]            lu_input_o;
  logic                   lu_valid_i;
  logic [4:0]             lu_width_i;
  logic [7:0]             lu_value_i;

  modport slave (
    input  flush_i, cfg_busy_i, req_valid_i, req_table_i, req_input_i,
    input  lu_valid_i, lu_width_i, lu_value_i,
    output cfg_idle_o, rsp_valid_o, rsp_width_o, rsp_value_o, req_err_o,
    output lu_req_o, lu_table_o, lu_input_o
  );

  modport master (
    output flush_i, cfg_busy_i, req_valid_i, req_table_i, req_input_i,
    output lu_valid_i, lu_width_i, lu_value_i,
    input  cfg_idle_o, rsp_valid_o, rsp_width_o, rsp_value_o, req_err_o,
    input  lu_req_o, lu_table_o, lu_input_o
  );
endinterface

// File: rtl/jpeg_dht_lookup_arb.sv
// rtl/jpeg_dht_lookup_arb.sv - round-robin sharing of one DHT lookup engine between decode lanes
module jpeg_dht_lookup_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  jpeg_dht_lookup_arb_if.slave  bus
);
  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      owner, rr_ptr, grant, grant_inc;
  logic [NUM_REQ-1:0] pend, err, lane_busy, accept, err_set, avail;
  logic [1:0]         tbl_q [NUM_REQ];
  logic [15:0]        in_q  [NUM_REQ];
  logic [4:0]         width_q;
  logic [7:0]         value_q;
  logic               drop_rsp, found, grant_ok, in_flight, issue_now, resp_now;
  logic [IW:0]        pos;

  assign in_flight = (state == ISSUE) || (state == WAIT);
  assign issue_now = (state == ISSUE) && !bus.flush_i;
  assign resp_now  = (state == RESP) && !bus.flush_i;

  // A lane in RESP is already idle, so its same-cycle request is accepted
  always_comb begin
    lane_busy = '0;
    accept    = '0;
    err_set   = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      lane_busy[n] = pend[n] || (in_flight && owner == IW'(n));
      accept[n]    = bus.req_valid_i[n] && !lane_busy[n] && !bus.flush_i;
      err_set[n]   = bus.req_valid_i[n] &&  lane_busy[n] && !bus.flush_i;
    end
  end

  assign avail = pend | accept;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(NUM_REQ)) pos = pos - (IW+1)'(NUM_REQ);
      for (int n = 0; n < NUM_REQ; n++) begin
        if (!found && avail[n] && pos == (IW+1)'(n)) begin
          grant = IW'(n);
          found = 1'b1;
        end
      end
    end
  end

  assign grant_ok  = found && !bus.cfg_busy_i && !bus.flush_i &&
                     ((state == IDLE) || (state == RESP));
  assign grant_inc = (grant == IW'(NUM_REQ-1)) ? '0 : grant + IW'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_ok) state_nxt = ISSUE;
      ISSUE:   state_nxt = bus.flush_i ? IDLE : WAIT;
      WAIT:    if (bus.lu_valid_i) state_nxt = (bus.flush_i || drop_rsp) ? IDLE : RESP;
      RESP:    state_nxt = grant_ok ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      pend     <= '0;
      err      <= '0;
      drop_rsp <= 1'b0;
      width_q  <= '0;
      value_q  <= '0;
      for (int n = 0; n < NUM_REQ; n++) begin
        tbl_q[n] <= '0;
        in_q[n]  <= '0;
      end
    end else begin
      state <= state_nxt;
      if (bus.flush_i) begin
        pend   <= '0;
        err    <= '0;
        rr_ptr <= '0;
      end else begin
        err <= err | err_set;
        for (int n = 0; n < NUM_REQ; n++) begin
          if (state == ISSUE && owner == IW'(n)) pend[n] <= 1'b0;
          else if (accept[n])                    pend[n] <= 1'b1;
        end
        if (grant_ok) begin
          owner  <= grant;
          rr_ptr <= grant_inc;
        end
      end
      for (int n = 0; n < NUM_REQ; n++) begin
        if (accept[n]) begin
          tbl_q[n] <= bus.req_table_i[2*n +: 2];
          in_q[n]  <= bus.req_input_i[16*n +: 16];
        end
      end
      // A flush during WAIT still has to absorb the engine's answer before going idle
      if (state == WAIT && bus.lu_valid_i) drop_rsp <= 1'b0;
      else if (state == WAIT && bus.flush_i) drop_rsp <= 1'b1;
      if (state == WAIT && bus.lu_valid_i && !bus.flush_i && !drop_rsp) begin
        width_q <= bus.lu_width_i;
        value_q <= bus.lu_value_i;
      end
    end
  end

  always_comb begin
    bus.rsp_valid_o = '0;
    for (int n = 0; n < NUM_REQ; n++)
      bus.rsp_valid_o[n] = resp_now && owner == IW'(n);
  end

  assign bus.lu_req_o    = issue_now;
  assign bus.lu_table_o  = issue_now ? tbl_q[owner] : 2'd0;
  assign bus.lu_input_o  = issue_now ? in_q[owner]  : 16'd0;
  assign bus.rsp_width_o = width_q;
  assign bus.rsp_value_o = value_q;
  assign bus.req_err_o   = err;
  assign bus.cfg_idle_o  = (state == IDLE) && (pend == '0);
endmodule

// File: tb/tb_jpeg_dht_lookup_arb.sv
// tb/tb_jpeg_dht_lookup_arb.sv - scoreboard bench for the DHT lookup arbiter with a behavioural engine
module tb_jpeg_dht_lookup_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   eng_lat = 1;
  int   lu_cnt = 0;
  int   rsp_cnt = 0;
  int   lu_cyc = 0;
  int   rsp_cyc = 0;
  int   lu_hist[$];

  typedef struct { logic [1:0] t; logic [15:0] x; } lu_t;
  typedef struct { int lane; logic [4:0] w; logic [7:0] v; } rsp_t;
  lu_t  exp_lu[$];
  rsp_t exp_rsp[$];

  jpeg_dht_lookup_arb_if #(.NUM_REQ(2)) bus();

  jpeg_dht_lookup_arb #(.NUM_REQ(2)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [12:0] eng(input logic [1:0] t, input logic [15:0] x);
    logic [4:0] w;
    w = 5'(x[15:12]) + 5'(t) + 5'd1;
    return {w, x[7:0] ^ {t, 6'b0}};
  endfunction

  task automatic expect_txn(input int lane, input logic [1:0] t, input logic [15:0] x);
    lu_t  l;
    rsp_t r;
    logic [12:0] e;
    l.t = t; l.x = x;
    e = eng(t, x);
    r.lane = lane; r.w = e[12:8]; r.v = e[7:0];
    exp_lu.push_back(l);
    exp_rsp.push_back(r);
  endtask

  task automatic expect_lu_only(input logic [1:0] t, input logic [15:0] x);
    lu_t l;
    l.t = t; l.x = x;
    exp_lu.push_back(l);
  endtask

  task automatic drive_req(input logic [1:0] mask, input logic [1:0] t0, input logic [15:0] x0,
                           input logic [1:0] t1, input logic [15:0] x1);
    bus.req_valid_i = mask;
    bus.req_table_i = {t1, t0};
    bus.req_input_i = {x1, x0};
    @(posedge clk); #1;
    bus.req_valid_i = '0;
  endtask

  task automatic pulse_flush();
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((exp_lu.size() != 0 || exp_rsp.size() != 0 || !bus.cfg_idle_o) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check_val({tag, "_timeout"}, 32'(n), 0);
    @(posedge clk); #1;
  endtask

  // Scoreboard: every engine request and lane response is popped and compared
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.lu_req_o) begin
        lu_cnt++;
        lu_cyc = cyc;
        lu_hist.push_back(cyc);
        if (exp_lu.size() == 0) check_val("lu_unexpected", 1, 0);
        else begin
          lu_t e;
          e = exp_lu.pop_front();
          check_val("lu_table", 32'(bus.lu_table_o), 32'(e.t));
          check_val("lu_input", 32'(bus.lu_input_o), 32'(e.x));
        end
      end
      if (bus.rsp_valid_o != '0) begin
        rsp_cnt++;
        rsp_cyc = cyc;
        if (exp_rsp.size() == 0) check_val("rsp_unexpected", 32'(bus.rsp_valid_o), 0);
        else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          check_val("rsp_lane", 32'(bus.rsp_valid_o), 32'(1) << r.lane);
          check_val("rsp_width", 32'(bus.rsp_width_o), 32'(r.w));
          check_val("rsp_value", 32'(bus.rsp_value_o), 32'(r.v));
        end
      end
    end
  end

  // Behavioural engine: answers eng_lat cycles after the request cycle
  initial begin
    bus.lu_valid_i = 1'b0;
    bus.lu_width_i = '0;
    bus.lu_value_i = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.lu_req_o) begin
        logic [12:0] e;
        e = eng(bus.lu_table_o, bus.lu_input_o);
        repeat (eng_lat) @(posedge clk);
        #1;
        bus.lu_valid_i = 1'b1;
        bus.lu_width_i = e[12:8];
        bus.lu_value_i = e[7:0];
        @(posedge clk); #1;
        bus.lu_valid_i = 1'b0;
      end
    end
  end

  initial begin
    int t0;
    int n;
    int lu_before;
    int rsp_before;
    bus.flush_i     = 1'b0;
    bus.cfg_busy_i  = 1'b0;
    bus.req_valid_i = '0;
    bus.req_table_i = '0;
    bus.req_input_i = '0;

    repeat (3) @(posedge clk); #1;
    check_val("rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
    check_val("rst_lu_req", 32'(bus.lu_req_o), 0);
    check_val("rst_req_err", 32'(bus.req_err_o), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst_cfg_idle", 32'(bus.cfg_idle_o), 1);

    // Single lane, minimum latency
    t0 = cyc;
    expect_txn(0, 2'd1, 16'hA5C3);
    drive_req(2'b01, 2'd1, 16'hA5C3, 2'd0, 16'h0);
    wait_done("single");
    check_val("single_lu_lat", 32'(lu_cyc - t0), 1);
    check_val("single_rsp_lat", 32'(rsp_cyc - t0), 3);

    // Contention with rr_ptr reset to 0 by a flush
    pulse_flush();
    lu_hist.delete();
    expect_txn(0, 2'd2, 16'h1357);
    expect_txn(1, 2'd3, 16'h2468);
    drive_req(2'b11, 2'd2, 16'h1357, 2'd3, 16'h2468);
    wait_done("contend");
    check_val("contend_n", 32'(lu_hist.size()), 2);
    if (lu_hist.size() == 2) check_val("contend_gap", 32'(lu_hist[1] - lu_hist[0]), 3);

    // Pointer now past lane0 after a lone lane0 grant -> lane1 wins next contention
    expect_txn(0, 2'd0, 16'hF00F);
    drive_req(2'b01, 2'd0, 16'hF00F, 2'd0, 16'h0);
    wait_done("lone0");
    expect_txn(1, 2'd1, 16'h0FF0);
    expect_txn(0, 2'd2, 16'h8001);
    drive_req(2'b11, 2'd2, 16'h8001, 2'd1, 16'h0FF0);
    wait_done("contend_rr");

    // Busy lane: second request one cycle later is dropped and flagged
    lu_before = lu_cnt;
    expect_txn(0, 2'd3, 16'h4321);
    drive_req(2'b01, 2'd3, 16'h4321, 2'd0, 16'h0);
    drive_req(2'b01, 2'd1, 16'hDEAD, 2'd0, 16'h0);
    wait_done("busy");
    check_val("busy_lu_count", 32'(lu_cnt - lu_before), 1);
    check_val("busy_err", 32'(bus.req_err_o), 2'b01);
    pulse_flush();
    check_val("busy_err_flushed", 32'(bus.req_err_o), 0);

    // Table load holds off grants but keeps the request pending
    lu_before = lu_cnt;
    bus.cfg_busy_i = 1'b1;
    @(posedge clk); #1;
    expect_txn(1, 2'd2, 16'h5A5A);
    drive_req(2'b10, 2'd0, 16'h0, 2'd2, 16'h5A5A);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("load_no_lu", 32'(lu_cnt - lu_before), 0);
    check_val("load_cfg_idle", 32'(bus.cfg_idle_o), 0);
    @(posedge clk); #1;
    t0 = cyc;
    bus.cfg_busy_i = 1'b0;
    wait_done("load");
    check_val("load_release_lat", 32'(lu_cyc - t0), 1);

    // Flush while waiting on a slow engine; a request in the flush cycle is dropped silently
    eng_lat = 5;
    lu_before = lu_cnt;
    rsp_before = rsp_cnt;
    expect_lu_only(2'd1, 16'h7777);
    drive_req(2'b01, 2'd1, 16'h7777, 2'd0, 16'h0);
    @(posedge clk); #1;
    bus.flush_i = 1'b1;
    bus.req_valid_i = 2'b10;
    bus.req_table_i = 4'b1100;
    bus.req_input_i = {16'h9999, 16'h0};
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    bus.req_valid_i = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.lu_valid_i && n < 20);
    check_val("flush_valid_seen", 32'(bus.lu_valid_i), 1);
    check_val("flush_idle_at_valid", 32'(bus.cfg_idle_o), 0);
    @(negedge clk);
    check_val("flush_idle_after", 32'(bus.cfg_idle_o), 1);
    check_val("flush_err", 32'(bus.req_err_o), 0);
    repeat (4) @(negedge clk);
    check_val("flush_no_rsp", 32'(rsp_cnt - rsp_before), 0);
    check_val("flush_lu_count", 32'(lu_cnt - lu_before), 1);
    @(posedge clk); #1;

    // Async reset in the middle of WAIT
    expect_lu_only(2'd2, 16'h1234);
    drive_req(2'b10, 2'd0, 16'h0, 2'd2, 16'h1234);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("arst_rsp_valid", 32'(bus.rsp_valid_o), 0);
    check_val("arst_lu_req", 32'(bus.lu_req_o), 0);
    check_val("arst_width", 32'(bus.rsp_width_o), 0);
    check_val("arst_value", 32'(bus.rsp_value_o), 0);
    check_val("arst_err", 32'(bus.req_err_o), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    eng_lat = 1;
    t0 = cyc;
    expect_txn(1, 2'd3, 16'hBEEF);
    drive_req(2'b10, 2'd0, 16'h0, 2'd3, 16'hBEEF);
    wait_done("post_reset");
    check_val("post_reset_rsp_lat", 32'(rsp_cyc - t0), 3);

    check_val("lu_queue_empty", 32'(exp_lu.size()), 0);
    check_val("rsp_queue_empty", 32'(exp_rsp.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
